// File: rtl/fabric_pkg.sv
`default_nettype none
// ============================================================================
// Module  : fabric_pkg
// Brief   : Reserved-range table, response codes and FSM state types shared
//           by the fabric default responder and its range classifier.
// Revision: 1.1
// ============================================================================
package fabric_pkg;

  localparam int RSVD_ADDR_W = 20;

  typedef struct packed {
    logic [RSVD_ADDR_W-1:0] lo;
    logic [RSVD_ADDR_W-1:0] hi;
  } range_t;

  localparam int RSVD_RANGE_CNT = 3;

  // Inclusive bounds; every address in these windows is read-as-zero / write-ignored.
  localparam range_t RSVD_RANGES [RSVD_RANGE_CNT] = '{
    '{lo: 20'h11000, hi: 20'h11FFF},
    '{lo: 20'h14000, hi: 20'h1FFFF},
    '{lo: 20'h90000, hi: 20'hFFFFF}
  };

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    W_IDLE    = 2'd0,
    W_NEED_W  = 2'd1,
    W_NEED_AW = 2'd2,
    W_RESP    = 2'd3
  } wr_state_t;

  typedef enum logic [0:0] {
    R_IDLE = 1'b0,
    R_RESP = 1'b1
  } rd_state_t;

  function automatic logic is_reserved(input logic [RSVD_ADDR_W-1:0] addr);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < RSVD_RANGE_CNT; i++) begin
      if (({1'b0, addr} >= {1'b0, RSVD_RANGES[i].lo}) &&
          ({1'b0, addr} <= {1'b0, RSVD_RANGES[i].hi}))
        hit = 1'b1;
    end
    return hit;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fabric_rsvd_match.sv
`default_nettype none
// ============================================================================
// Module  : fabric_rsvd_match
// Brief   : Combinational address classifier: reserved range -> OKAY,
//           anything else -> DECERR.
// Revision: 1.1
// ============================================================================
module fabric_rsvd_match
  import fabric_pkg::*;
#(
  parameter int ADDR_W = 20
) (
  input  logic [ADDR_W-1:0] addr,
  output logic              rsvd,
  output logic [1:0]        resp
);

  logic [RSVD_ADDR_W-1:0]    w_addr;
  logic [RSVD_RANGE_CNT-1:0] w_hit;

  assign w_addr = RSVD_ADDR_W'(addr);

  // The extra zero bit keeps a top-of-space bound from folding into a constant compare.
  for (genvar gi = 0; gi < RSVD_RANGE_CNT; gi++) begin : g_range
    assign w_hit[gi] = ({1'b0, w_addr} >= {1'b0, RSVD_RANGES[gi].lo}) &&
                       ({1'b0, w_addr} <= {1'b0, RSVD_RANGES[gi].hi});
  end

  assign rsvd = |w_hit;
  assign resp = rsvd ? RESP_OKAY : RESP_DECERR;

  always_comb begin
    assert (rsvd == is_reserved(w_addr));
  end

endmodule
`default_nettype wire

// File: rtl/fabric_default_responder.sv
`default_nettype none
// ============================================================================
// Module  : fabric_default_responder
// Brief   : AXI4-Lite default slave: reserved ranges answer OKAY/RAZ-WI, all
//           else DECERR, with first-error capture and saturating hit counters.
// Revision: 1.1
// ============================================================================
module fabric_default_responder
  import fabric_pkg::*;
#(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 64,
  parameter int CNT_W  = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                s_awvalid,
  output logic                s_awready,
  input  logic [ADDR_W-1:0]   s_awaddr,
  input  logic                s_wvalid,
  output logic                s_wready,
  input  logic [DATA_W-1:0]   s_wdata,
  input  logic [DATA_W/8-1:0] s_wstrb,
  output logic                s_bvalid,
  input  logic                s_bready,
  output logic [1:0]          s_bresp,
  input  logic                s_arvalid,
  output logic                s_arready,
  input  logic [ADDR_W-1:0]   s_araddr,
  output logic                s_rvalid,
  input  logic                s_rready,
  output logic [DATA_W-1:0]   s_rdata,
  output logic [1:0]          s_rresp,
  output logic [CNT_W-1:0]    rsvd_hit_cnt,
  output logic [CNT_W-1:0]    decerr_cnt,
  output logic                err_valid,
  output logic [ADDR_W-1:0]   err_addr,
  output logic                err_is_wr,
  input  logic                err_clr
);

  wr_state_t         r_wr_state, w_wr_state_nxt;
  rd_state_t         r_rd_state, w_rd_state_nxt;
  logic [ADDR_W-1:0] r_awaddr;
  logic [1:0]        r_bresp, r_rresp;
  logic [CNT_W-1:0]  r_rsvd_cnt, r_decerr_cnt;
  logic              r_err_valid, r_err_is_wr;
  logic [ADDR_W-1:0] r_err_addr;

  logic              w_aw_hs, w_wr_done, w_ar_hs;
  logic [ADDR_W-1:0] w_wr_addr;
  logic              w_wr_rsvd, w_rd_rsvd;
  logic [1:0]        w_wr_resp, w_rd_resp;
  logic              w_wr_err_evt, w_rd_err_evt;
  logic [1:0]        w_rsvd_inc, w_decerr_inc;
  logic [CNT_W-1:0]  w_rsvd_base, w_decerr_base;
  logic              w_unused_ok;

  assign w_unused_ok = &{1'b0, s_wdata, s_wstrb};

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] base,
                                               input logic [1:0]       inc);
    logic [CNT_W:0] sum;
    sum = {1'b0, base} + {{(CNT_W-1){1'b0}}, inc};
    return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
  endfunction

  always_comb begin
    w_wr_state_nxt = r_wr_state;
    s_awready      = 1'b0;
    s_wready       = 1'b0;
    s_bvalid       = 1'b0;
    w_aw_hs        = 1'b0;
    w_wr_done      = 1'b0;
    case (r_wr_state)
      W_IDLE: begin
        s_awready = 1'b1;
        s_wready  = 1'b1;
        w_aw_hs   = s_awvalid;
        if (s_awvalid && s_wvalid) begin
          w_wr_state_nxt = W_RESP;
          w_wr_done      = 1'b1;
        end else if (s_awvalid) begin
          w_wr_state_nxt = W_NEED_W;
        end else if (s_wvalid) begin
          w_wr_state_nxt = W_NEED_AW;
        end
      end
      W_NEED_W: begin
        s_wready = 1'b1;
        if (s_wvalid) begin
          w_wr_state_nxt = W_RESP;
          w_wr_done      = 1'b1;
        end
      end
      W_NEED_AW: begin
        s_awready = 1'b1;
        w_aw_hs   = s_awvalid;
        if (s_awvalid) begin
          w_wr_state_nxt = W_RESP;
          w_wr_done      = 1'b1;
        end
      end
      W_RESP: begin
        s_bvalid = 1'b1;
        if (s_bready) w_wr_state_nxt = W_IDLE;
      end
      default: w_wr_state_nxt = W_IDLE;
    endcase
  end

  always_comb begin
    w_rd_state_nxt = r_rd_state;
    s_arready      = 1'b0;
    s_rvalid       = 1'b0;
    w_ar_hs        = 1'b0;
    case (r_rd_state)
      R_IDLE: begin
        s_arready = 1'b1;
        if (s_arvalid) begin
          w_ar_hs        = 1'b1;
          w_rd_state_nxt = R_RESP;
        end
      end
      R_RESP: begin
        s_rvalid = 1'b1;
        if (s_rready) w_rd_state_nxt = R_IDLE;
      end
      default: w_rd_state_nxt = R_IDLE;
    endcase
  end

  // The write is classified on the cycle it completes, so use the live AW address when it arrives then.
  assign w_wr_addr = w_aw_hs ? s_awaddr : r_awaddr;

  fabric_rsvd_match #(.ADDR_W(ADDR_W)) u_wr_match (
    .addr (w_wr_addr),
    .rsvd (w_wr_rsvd),
    .resp (w_wr_resp)
  );

  fabric_rsvd_match #(.ADDR_W(ADDR_W)) u_rd_match (
    .addr (s_araddr),
    .rsvd (w_rd_rsvd),
    .resp (w_rd_resp)
  );

  assign w_wr_err_evt  = w_wr_done & ~w_wr_rsvd;
  assign w_rd_err_evt  = w_ar_hs & ~w_rd_rsvd;
  assign w_rsvd_inc    = {1'b0, w_wr_done & w_wr_rsvd} + {1'b0, w_ar_hs & w_rd_rsvd};
  assign w_decerr_inc  = {1'b0, w_wr_err_evt} + {1'b0, w_rd_err_evt};
  assign w_rsvd_base   = err_clr ? '0 : r_rsvd_cnt;
  assign w_decerr_base = err_clr ? '0 : r_decerr_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_state <= W_IDLE;
      r_rd_state <= R_IDLE;
      r_awaddr   <= '0;
      r_bresp    <= RESP_OKAY;
      r_rresp    <= RESP_OKAY;
    end else begin
      r_wr_state <= w_wr_state_nxt;
      r_rd_state <= w_rd_state_nxt;
      if (w_aw_hs)   r_awaddr <= s_awaddr;
      if (w_wr_done) r_bresp  <= w_wr_resp;
      if (w_ar_hs)   r_rresp  <= w_rd_resp;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsvd_cnt   <= '0;
      r_decerr_cnt <= '0;
      r_err_valid  <= 1'b0;
      r_err_addr   <= '0;
      r_err_is_wr  <= 1'b0;
    end else begin
      r_rsvd_cnt   <= sat_add(w_rsvd_base, w_rsvd_inc);
      r_decerr_cnt <= sat_add(w_decerr_base, w_decerr_inc);
      // Write wins a same-cycle tie; a clear frees the record for this cycle's error.
      if (err_clr || !r_err_valid) begin
        if (w_wr_err_evt) begin
          r_err_valid <= 1'b1;
          r_err_addr  <= w_wr_addr;
          r_err_is_wr <= 1'b1;
        end else if (w_rd_err_evt) begin
          r_err_valid <= 1'b1;
          r_err_addr  <= s_araddr;
          r_err_is_wr <= 1'b0;
        end else if (err_clr) begin
          r_err_valid <= 1'b0;
        end
      end
    end
  end

  assign s_bresp      = r_bresp;
  assign s_rresp      = r_rresp;
  assign s_rdata      = '0;
  assign rsvd_hit_cnt = r_rsvd_cnt;
  assign decerr_cnt   = r_decerr_cnt;
  assign err_valid    = r_err_valid;
  assign err_addr     = r_err_addr;
  assign err_is_wr    = r_err_is_wr;

endmodule
`default_nettype wire

// File: tb/tb_fabric_default_responder.sv
`default_nettype none
// ============================================================================
// Module  : tb_fabric_default_responder
// Brief   : Directed scoreboard bench for the fabric default responder.
// Revision: 1.1
// ============================================================================
module tb_fabric_default_responder;

  localparam int ADDR_W = 20;
  localparam int DATA_W = 64;
  localparam int CNT_W  = 16;
  localparam logic [1:0] OK = 2'b00;
  localparam logic [1:0] DE = 2'b11;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                s_awvalid, s_awready;
  logic [ADDR_W-1:0]   s_awaddr;
  logic                s_wvalid, s_wready;
  logic [DATA_W-1:0]   s_wdata;
  logic [DATA_W/8-1:0] s_wstrb;
  logic                s_bvalid, s_bready;
  logic [1:0]          s_bresp;
  logic                s_arvalid, s_arready;
  logic [ADDR_W-1:0]   s_araddr;
  logic                s_rvalid, s_rready;
  logic [DATA_W-1:0]   s_rdata;
  logic [1:0]          s_rresp;
  logic [CNT_W-1:0]    rsvd_hit_cnt, decerr_cnt;
  logic                err_valid;
  logic [ADDR_W-1:0]   err_addr;
  logic                err_is_wr;
  logic                err_clr;

  int n_cmp = 0;
  int n_bad = 0;
  int b_beats = 0;
  int r_beats = 0;
  logic [1:0] b_q[$];
  logic [1:0] r_q[$];
  logic       b_hold = 1'b0;
  logic [1:0] b_prev = 2'b00;

  fabric_default_responder #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
    .rsvd_hit_cnt(rsvd_hit_cnt), .decerr_cnt(decerr_cnt),
    .err_valid(err_valid), .err_addr(err_addr), .err_is_wr(err_is_wr),
    .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every completed B/R beat.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (s_bvalid && b_hold) chk("bresp_stable", 64'(s_bresp), 64'(b_prev));
      if (s_bvalid && s_bready) begin
        b_beats++;
        if (b_q.size() == 0) chk("unexpected_b_beat", 64'(1), 64'(0));
        else chk("bresp", 64'(s_bresp), 64'(b_q.pop_front()));
      end
      if (s_rvalid && s_rready) begin
        r_beats++;
        if (r_q.size() == 0) chk("unexpected_r_beat", 64'(1), 64'(0));
        else begin
          chk("rresp", 64'(s_rresp), 64'(r_q.pop_front()));
          chk("rdata", s_rdata, 64'(0));
        end
      end
      b_hold = s_bvalid && !s_bready;
      b_prev = s_bresp;
    end else begin
      b_hold = 1'b0;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic issue(input bit do_aw, input bit do_w, input bit do_ar,
                       input logic [ADDR_W-1:0] awa, input logic [ADDR_W-1:0] ara,
                       input logic [1:0] bexp, input logic [1:0] rexp, input bit clr);
    bit p_aw, p_w, p_ar, rd_aw, rd_w, rd_ar;
    int budget;
    if (do_aw) b_q.push_back(bexp);
    if (do_ar) r_q.push_back(rexp);
    s_awvalid = do_aw; s_awaddr = awa;
    s_wvalid  = do_w;  s_wdata  = {$urandom, $urandom}; s_wstrb = '1;
    s_arvalid = do_ar; s_araddr = ara;
    err_clr   = clr;
    p_aw = do_aw; p_w = do_w; p_ar = do_ar; budget = 0;
    while ((p_aw || p_w || p_ar) && budget < 50) begin
      @(negedge clk);
      rd_aw = s_awready; rd_w = s_wready; rd_ar = s_arready;
      @(posedge clk); #1;
      err_clr = 1'b0;
      if (p_aw && rd_aw) begin p_aw = 1'b0; s_awvalid = 1'b0; end
      if (p_w  && rd_w)  begin p_w  = 1'b0; s_wvalid  = 1'b0; end
      if (p_ar && rd_ar) begin p_ar = 1'b0; s_arvalid = 1'b0; end
      budget++;
    end
    if (p_aw || p_w || p_ar) chk("handshake_timeout", 64'(1), 64'(0));
    s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0; err_clr = 1'b0;
  endtask

  task automatic rd(input logic [ADDR_W-1:0] a, input logic [1:0] e);
    issue(1'b0, 1'b0, 1'b1, '0, a, OK, e, 1'b0);
    idle(2);
  endtask

  initial begin
    int b0, r0;
    rst_n = 1'b0; s_awvalid = 0; s_wvalid = 0; s_arvalid = 0;
    s_awaddr = '0; s_araddr = '0; s_wdata = '0; s_wstrb = '0;
    s_bready = 1'b1; s_rready = 1'b1; err_clr = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_awready", 64'(s_awready), 64'(1));
    chk("rst_wready",  64'(s_wready),  64'(1));
    chk("rst_arready", 64'(s_arready), 64'(1));
    chk("rst_bvalid",  64'(s_bvalid),  64'(0));
    chk("rst_rvalid",  64'(s_rvalid),  64'(0));
    chk("rst_cnts",    64'({rsvd_hit_cnt, decerr_cnt}), 64'(0));
    chk("rst_err",     64'({err_valid, err_addr, err_is_wr}), 64'(0));
    @(posedge clk); #1 rst_n = 1'b1;
    idle(2);

    // Reserved read: one-cycle latency, RAZ.
    issue(1'b0, 1'b0, 1'b1, '0, 20'h11004, OK, OK, 1'b0);
    @(negedge clk);
    chk("rd_latency_rvalid", 64'(s_rvalid), 64'(1));
    chk("rsvd_cnt_1", 64'(rsvd_hit_cnt), 64'(1));
    chk("err_valid_0", 64'(err_valid), 64'(0));
    idle(2);

    // First DECERR captured; later write does not overwrite it.
    rd(20'h12000, DE);
    chk("decerr_cnt_1", 64'(decerr_cnt), 64'(1));
    chk("err_rec_rd", 64'({err_valid, err_is_wr}), 64'(2'b10));
    chk("err_addr_rd", 64'(err_addr), 64'(20'h12000));
    issue(1'b1, 1'b1, 1'b0, 20'h13000, '0, DE, OK, 1'b0);
    idle(2);
    chk("err_addr_kept", 64'(err_addr), 64'(20'h12000));
    chk("decerr_cnt_2", 64'(decerr_cnt), 64'(2));

    // Range boundaries.
    rd(20'h14000, OK); rd(20'h1FFFF, OK); rd(20'h90000, OK); rd(20'hFFFFF, OK);
    rd(20'h13FFF, DE); rd(20'h20000, DE); rd(20'h8FFFF, DE);
    chk("rsvd_cnt_5", 64'(rsvd_hit_cnt), 64'(5));
    chk("decerr_cnt_5", 64'(decerr_cnt), 64'(5));

    // W leads AW by 3 cycles; B held off for 5 cycles.
    s_bready = 1'b0;
    issue(1'b0, 1'b1, 1'b0, '0, '0, OK, OK, 1'b0);
    idle(3);
    issue(1'b1, 1'b0, 1'b0, 20'h90010, '0, OK, OK, 1'b0);
    b0 = b_beats;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("b_hold_valid", 64'(s_bvalid), 64'(1));
      chk("b_hold_resp", 64'(s_bresp), 64'(OK));
    end
    @(posedge clk); #1 s_bready = 1'b1;
    idle(5);
    chk("b_single_beat", 64'(b_beats), 64'(b0 + 1));
    chk("rsvd_cnt_6", 64'(rsvd_hit_cnt), 64'(6));

    // Simultaneous write/read DECERR after clearing the record.
    @(posedge clk); #1 err_clr = 1'b1;
    @(posedge clk); #1 err_clr = 1'b0;
    chk("clr_cnts", 64'({rsvd_hit_cnt, decerr_cnt}), 64'(0));
    chk("clr_err_valid", 64'(err_valid), 64'(0));
    issue(1'b1, 1'b1, 1'b1, 20'h20000, 20'h30000, DE, DE, 1'b0);
    idle(2);
    chk("dual_decerr_cnt", 64'(decerr_cnt), 64'(2));
    chk("dual_err_is_wr", 64'({err_valid, err_is_wr}), 64'(2'b11));
    chk("dual_err_addr", 64'(err_addr), 64'(20'h20000));
    issue(1'b0, 1'b0, 1'b1, '0, 20'h40000, OK, DE, 1'b1);
    idle(2);
    chk("clr_new_err_addr", 64'(err_addr), 64'(20'h40000));
    chk("clr_new_err_rec", 64'({err_valid, err_is_wr}), 64'(2'b10));
    chk("clr_new_decerr_cnt", 64'(decerr_cnt), 64'(1));

    // Saturation: 32767 reserved pairs reach 0xFFFE, then +2 clamps.
    for (int i = 0; i < 32767; i++)
      issue(1'b1, 1'b1, 1'b1, 20'h11000, 20'h14000, OK, OK, 1'b0);
    idle(3);
    chk("rsvd_cnt_fffe", 64'(rsvd_hit_cnt), 64'(16'hFFFE));
    issue(1'b1, 1'b1, 1'b1, 20'h11000, 20'h14000, OK, OK, 1'b0);
    idle(3);
    chk("rsvd_cnt_sat", 64'(rsvd_hit_cnt), 64'(16'hFFFF));
    issue(1'b1, 1'b1, 1'b1, 20'h1FFFF, 20'h90000, OK, OK, 1'b0);
    idle(3);
    chk("rsvd_cnt_sat_hold", 64'(rsvd_hit_cnt), 64'(16'hFFFF));
    chk("decerr_cnt_kept", 64'(decerr_cnt), 64'(1));

    // Reset during R_RESP drops the pending beat.
    s_rready = 1'b0;
    issue(1'b0, 1'b0, 1'b1, '0, 20'h11004, OK, OK, 1'b0);
    @(negedge clk);
    chk("pre_rst_rvalid", 64'(s_rvalid), 64'(1));
    r0 = r_beats;
    @(posedge clk); #2 rst_n = 1'b0;
    r_q.delete();
    #1;
    chk("rst_async_rvalid", 64'(s_rvalid), 64'(0));
    chk("rst_async_cnt", 64'(rsvd_hit_cnt), 64'(0));
    s_rready = 1'b1;
    @(posedge clk); #1 rst_n = 1'b1;
    idle(6);
    chk("no_stale_r_beat", 64'(r_beats), 64'(r0));
    chk("post_rst_rvalid", 64'(s_rvalid), 64'(0));

    chk("b_queue_drained", 64'(b_q.size()), 64'(0));
    chk("r_queue_drained", 64'(r_q.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fabric_default_responder.md
Name: fabric_default_responder

Overview:
- AXI4-Lite default slave for the APF/BPF fabric. The fabric routes every access that misses all mapped ports to this block.
- Accesses that fall inside the reserved (unused) ranges complete as read-as-zero / write-ignored with OKAY.
- Any other access completes with DECERR, and the block latches first-error diagnostics and keeps saturating hit counters for the management CSR block.

Parameters:
- ADDR_W, 20, address width compared against the range table.
- DATA_W, 64, read/write data width.
- CNT_W, 16, width of each saturating hit counter.

Ports:
- clk  in  1  fabric clock
- rst_n  in  1  reset
- s_awvalid  in  1  write address valid
- s_awready  out  1  write address ready
- s_awaddr  in  ADDR_W  write address
- s_wvalid  in  1  write data valid
- s_wready  out  1  write data ready
- s_wdata  in  DATA_W  write data (discarded)
- s_wstrb  in  DATA_W/8  write strobes (discarded)
- s_bvalid  out  1  write response valid
- s_bready  in  1  write response ready
- s_bresp  out  2  write response
- s_arvalid  in  1  read address valid
- s_arready  out  1  read address ready
- s_araddr  in  ADDR_W  read address
- s_rvalid  out  1  read data valid
- s_rready  in  1  read data ready
- s_rdata  out  DATA_W  read data
- s_rresp  out  2  read response
- rsvd_hit_cnt  out  CNT_W  accesses that hit reserved ranges
- decerr_cnt  out  CNT_W  accesses that got DECERR
- err_valid  out  1  first-error record is held
- err_addr  out  ADDR_W  address of the first DECERR access
- err_is_wr  out  1  first DECERR access was a write
- err_clr  in  1  single-cycle pulse that clears the error record and both counters

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: all outputs are 0, except s_awready, s_wready and s_arready, which are 1 (idle states). s_bresp and s_rresp are 2'b00.
- Address classification (combinational): reserved when lo <= addr <= hi for any table entry, inclusive at both ends. Reserved → OKAY (2'b00). Otherwise → DECERR (2'b11).
- Write FSM states: W_IDLE, W_NEED_W, W_NEED_AW, W_RESP.
  - W_IDLE: awready=1, wready=1.
    - AW and W handshake in the same cycle → W_RESP.
    - AW only → W_NEED_W; the address is registered.
    - W only → W_NEED_AW.
  - W_NEED_W: wready=1, awready=0. W handshake → W_RESP.
  - W_NEED_AW: awready=1, wready=0. AW handshake → W_RESP.
  - W_RESP: bvalid=1, bresp is held stable; stays until bready=1, then → W_IDLE.
  - Minimum latency: bvalid asserts 1 cycle after the cycle that completes both AW and W. One write outstanding.
- Read FSM states: R_IDLE (arready=1) and R_RESP (rvalid=1).
  - AR handshake → R_RESP the next cycle, with rdata = 0 and rresp from classification.
  - rdata and rresp are held until rready; R_RESP → R_IDLE on rready. One read outstanding.
- Read and write FSMs are independent and may complete on the same cycle.
- Statistics update on the AR handshake for reads, and on the cycle the write FSM enters W_RESP for writes.
  - Reserved access → rsvd_hit_cnt +1. DECERR → decerr_cnt +1.
  - A simultaneous read and write of the same class in one cycle → that counter +2.
  - Counters saturate at all-ones and never wrap; +2 from all-ones-minus-one saturates.
- Error capture: on a DECERR event while err_valid=0, latch err_addr and err_is_wr, and set err_valid=1. Later errors do not overwrite the record.
  - Simultaneous read and write DECERR with err_valid=0: the write is captured.
- err_clr: clears err_valid and both counters. If a new DECERR occurs in the same cycle as err_clr, the new error is captured, and the counter restarts at the increment for that cycle.
- rst_n assertion mid-transaction: both FSMs return to idle and any pending response is dropped. No b or r beat is issued after reset releases.

Decomposition:
- fabric_pkg: keep the existing reserved-range table and its count constant. Add:
  - typedef range_t with fields lo and hi.
  - function is_reserved(addr), shared by this block and its assertions.
  - localparams RESP_OKAY = 2'b00 and RESP_DECERR = 2'b11.
- Sub-module fabric_rsvd_match: a purely combinational classifier, one instance per channel (AW-side registered address and AR). It makes the range compare reusable by the BPF variant.

Test Plan:
- Read 0x11004 → rvalid the next cycle, rdata=0, rresp=2'b00, rsvd_hit_cnt=1, err_valid=0.
- Read 0x12000 → rresp=2'b11, decerr_cnt=1, err_valid=1, err_addr=0x12000, err_is_wr=0. Then write 0x13000 → bresp=2'b11, err_addr is still 0x12000.
- Boundaries: reads at 0x14000, 0x1FFFF, 0x90000 and 0xFFFFF → OKAY. Reads at 0x13FFF, 0x20000 and 0x8FFFF → DECERR.
- W beat 3 cycles before AW=0x90010, with bready held low 5 cycles → bvalid is stable with bresp=2'b00, and only one B beat occurs.
- Simultaneous write 0x20000 and read 0x30000 → both DECERR, decerr_cnt=2, err_is_wr=1, err_addr=0x20000. err_clr plus a new read DECERR to 0x40000 in the same cycle → err_addr=0x40000, decerr_cnt=1.
- Preload counters to 0xFFFE, then a simultaneous reserved read and write → rsvd_hit_cnt=0xFFFF, and it stays 0xFFFF on further hits. rst_n low during R_RESP → rvalid drops at once and no stale beat appears after release.
